// File: rtl/demux_frame_sequencer_pkg.sv
// Shared types and constants for the 8-way demux frame sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   state_e       - sequencer FSM states
//   SLOTS         - number of demux outputs / word bits per frame
//   sel_for_slot  - select code that routes word bit k to demux output k
package demux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT  = 2'd1,
    BLANK = 2'd2
  } state_e;

  localparam int SLOTS  = 8;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;

  // The demux decodes select code c to output (7 - c), so inverting the slot
  // index lands word bit k on output k.
  function automatic logic [SEL_W-1:0] sel_for_slot(input logic [SEL_W-1:0] k);
    return ~k;
  endfunction

endpackage

// File: rtl/demux_frame_sequencer_if.sv
// Handshake + demux drive bundle between the upstream word source and the sequencer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready; a word transfers when both are high at a rising edge.
//
// Signals:
//   in_valid, in_data (8) - word offered by the source (master drives)
//   in_ready              - sequencer can accept a word (slave drives)
//   i0, s2, s1, s0        - demux data input and select lines (s2 = MSB)
//   slot_strobe, slot_idx - current slot is valid / word bit index presented
//   busy, done            - frame in progress / one-cycle end-of-frame pulse
import demux_seq_pkg::*;

interface demux_frame_sequencer_if;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              i0;
  logic              s2;
  logic              s1;
  logic              s0;
  logic              slot_strobe;
  logic [SEL_W-1:0]  slot_idx;
  logic              busy;
  logic              done;

  // Word source side.
  modport master (
    output in_valid, in_data,
    input  in_ready, i0, s2, s1, s0, slot_strobe, slot_idx, busy, done
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, i0, s2, s1, s0, slot_strobe, slot_idx, busy, done
  );

endinterface

// File: rtl/demux_frame_sequencer_slot_timer.sv
// Slot hold counter: counts 0..HOLD_CYCLES-1 while a slot is active.
// Latency: expire is combinational from the registered count (high in the last slot cycle).
// Backpressure: none; restart forces the count back to 0.
//
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset (count -> 0)
//   restart - hold the count at 0 (asserted whenever no slot is active)
//   expire  - last cycle of the current slot
import demux_seq_pkg::*;

module slot_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || cnt_q == LAST) begin
      // Wrapping on LAST lets consecutive slots run without a restart pulse.
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = ~restart & (cnt_q == LAST);

endmodule

// File: rtl/demux_frame_sequencer.sv
// Serialises an 8-bit word across an 8-way demux: slot k drives select ~k and i0 = word[k].
// Latency: word accepted at edge T presents slot 0 from T+1; each slot lasts HOLD_CYCLES.
// Backpressure: in_ready high only in IDLE (and never during reset); one word per frame.
//
// Parameters:
//   HOLD_CYCLES - cycles each slot is held, 1..16
// Build option:
//   DEMUX_SEQ_BLANK_EN - insert one BLANK cycle (i0 = 0, select advances) between slots
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset; aborts any frame without a done pulse
//   bus - demux_frame_sequencer_if.slave (handshake in, demux drive + status out)
import demux_seq_pkg::*;

module demux_frame_sequencer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  demux_frame_sequencer_if.slave    bus
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 16) begin : g_bad_hold
    $error("demux_frame_sequencer: HOLD_CYCLES must be in 1..16");
  end

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_d;
  logic [SEL_W-1:0]  k_q;
  logic [SEL_W-1:0]  k_d;
  logic              i0_q;
  logic              i0_d;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_d;
  logic              strobe_q;
  logic              strobe_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;

  logic              in_ready;
  logic              restart;
  logic              expire;

  // Combinational so that no word can be taken while reset is held.
  assign in_ready = (state_q == IDLE) & ~rst;

  // The counter only runs inside SLOT; it sits at 0 in IDLE and BLANK.
  assign restart = (state_q != SLOT);

  slot_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_slot_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .expire  (expire)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    k_d     = k_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          word_d  = bus.in_data;
          k_d     = '0;
          state_d = SLOT;
        end
      end
      SLOT: begin
        if (expire) begin
          if (k_q == SEL_W'(SLOTS - 1)) begin
            k_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d = k_q + 1'b1;
`ifdef DEMUX_SEQ_BLANK_EN
            state_d = BLANK;
`else
            state_d = SLOT;
`endif
          end
        end
      end
`ifdef DEMUX_SEQ_BLANK_EN
      BLANK: begin
        state_d = SLOT;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    // k_d is 0 whenever the next state is IDLE, which gives select 3'b111 there;
    // in BLANK the select already shows the upcoming slot while i0 stays 0.
    i0_d     = (state_d == SLOT) & word_d[k_d];
    sel_d    = sel_for_slot(k_d);
    strobe_d = (state_d == SLOT);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      k_q      <= '0;
      i0_q     <= 1'b0;
      sel_q    <= 3'b111;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      k_q      <= k_d;
      i0_q     <= i0_d;
      sel_q    <= sel_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.in_ready              = in_ready;
  assign bus.i0                    = i0_q;
  assign {bus.s2, bus.s1, bus.s0}  = sel_q;
  assign bus.slot_strobe           = strobe_q;
  assign bus.slot_idx              = k_q;
  assign bus.busy                  = busy_q;
  assign bus.done                  = done_q;

endmodule
